// File: rtl/sha256_msg_padder.sv
// SHA-256 message padder: packs 64-bit input beats into padded 512-bit blocks.
// Define SHA256_PAD_BSWAP_EN to byte-reverse each input beat (little-endian DMA sources).
module sha256_msg_padder #(
  parameter int unsigned LEN_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [LEN_W-1:0] msg_bytes,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [63:0]      in_data,
  output logic             blk_valid,
  input  logic             blk_ready,
  output logic [511:0]     blk_data,
  output logic             blk_first,
  output logic             blk_last,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {S_IDLE, S_FILL, S_EMIT} state_t;

  state_t           state;
  logic [LEN_W+2:0] rem;
  logic [63:0]      bit_len;
  logic [2:0]       w;
  logic             marker_done;
  logic             first_blk;
  logic [511:0]     blk_reg;

  logic [63:0]      beat;
  logic [63:0]      word;
  logic [63:0]      keep_mask;
  logic [63:0]      marker;
  logic             advance;
  logic             word_last;
  logic             rem_ge8;
  logic             rem_nz;

`ifdef SHA256_PAD_BSWAP_EN
  always_comb begin
    beat = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      beat[8*i +: 8] = in_data[56-8*i +: 8];
    end
  end
`else
  assign beat = in_data;
`endif

  assign rem_ge8   = |rem[LEN_W+2:3];
  assign rem_nz    = |rem;
  // Tail beat: keep the first rem bytes, marker lands directly after them.
  assign keep_mask = ~({64{1'b1}} >> {rem[2:0], 3'b000});
  assign marker    = 64'h8000_0000_0000_0000 >> {rem[2:0], 3'b000};

  always_comb begin
    word      = '0;
    advance   = 1'b0;
    word_last = 1'b0;
    if (rem_ge8) begin
      word    = beat;
      advance = in_valid;
    end else if (rem_nz) begin
      word    = (beat & keep_mask) | marker;
      advance = in_valid;
    end else if (!marker_done) begin
      word    = 64'h8000_0000_0000_0000;
      advance = 1'b1;
    end else begin
      advance = 1'b1;
      if (w == 3'd7) begin
        word      = bit_len;
        word_last = 1'b1;
      end
    end
  end

  assign in_ready = (state == S_FILL) && rem_nz;
  assign busy     = (state != S_IDLE);
  assign blk_data = blk_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= S_IDLE;
      rem         <= '0;
      bit_len     <= '0;
      w           <= '0;
      marker_done <= 1'b0;
      first_blk   <= 1'b0;
      blk_reg     <= '0;
      blk_valid   <= 1'b0;
      blk_first   <= 1'b0;
      blk_last    <= 1'b0;
      done        <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            rem         <= {3'b000, msg_bytes};
            bit_len     <= 64'({msg_bytes, 3'b000});
            w           <= '0;
            marker_done <= 1'b0;
            first_blk   <= 1'b1;
            blk_reg     <= '0;
            state       <= S_FILL;
          end
        end
        S_FILL: begin
          if (advance) begin
            blk_reg[{~w, 6'd0} +: 64] <= word;
            if (rem_ge8) begin
              rem <= rem - (LEN_W+3)'(8);
            end else if (rem_nz) begin
              rem         <= '0;
              marker_done <= 1'b1;
            end else begin
              marker_done <= 1'b1;
            end
            w <= w + 3'd1;
            if (w == 3'd7) begin
              state     <= S_EMIT;
              blk_valid <= 1'b1;
              blk_first <= first_blk;
              blk_last  <= word_last;
            end
          end
        end
        S_EMIT: begin
          if (blk_ready) begin
            blk_valid <= 1'b0;
            blk_first <= 1'b0;
            blk_last  <= 1'b0;
            first_blk <= 1'b0;
            blk_reg   <= '0;
            if (blk_last) begin
              state <= S_IDLE;
              done  <= 1'b1;
            end else begin
              state <= S_FILL;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sha256_msg_padder.sv
// Scoreboard bench for sha256_msg_padder: directed messages, expected blocks queued up front.
module tb_sha256_msg_padder;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         start = 1'b0;
  logic [31:0]  msg_bytes = '0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [63:0]  in_data = '0;
  logic         blk_valid;
  logic         blk_ready = 1'b1;
  logic [511:0] blk_data;
  logic         blk_first;
  logic         blk_last;
  logic         busy;
  logic         done;

  sha256_msg_padder #(.LEN_W(32)) dut (
    .clk(clk), .rst(rst), .start(start), .msg_bytes(msg_bytes),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .blk_valid(blk_valid), .blk_ready(blk_ready), .blk_data(blk_data),
    .blk_first(blk_first), .blk_last(blk_last), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [511:0] d;
    logic         f;
    logic         l;
  } blk_t;

  blk_t       exp_q[$];
  int         pass_cnt = 0;
  int         total_cnt = 0;
  logic [7:0] msg [0:255];
  logic       done_due = 1'b0;

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] req);
    total_cnt++;
    if (act === req) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, req);
  endtask

  task automatic push_blk(input logic [511:0] d, input logic f, input logic l);
    blk_t b;
    b.d = d; b.f = f; b.l = l;
    exp_q.push_back(b);
  endtask

  // Textbook padding over a byte array, then split into blocks.
  task automatic push_model(input int L, input int max_blocks);
    logic [7:0]  p [0:511];
    logic [63:0] bl;
    logic [511:0] d;
    int n, nblk;
    nblk = (L + 8) / 64 + 1;
    n    = nblk * 64;
    bl   = 64'(L) * 64'd8;
    for (int i = 0; i < n; i++) p[i] = (i < L) ? msg[i] : ((i == L) ? 8'h80 : 8'h00);
    for (int j = 0; j < 8; j++) p[n-8+j] = bl[63-8*j -: 8];
    for (int b = 0; b < nblk && b < max_blocks; b++) begin
      for (int j = 0; j < 64; j++) d[511-8*j -: 8] = p[64*b + j];
      push_blk(d, b == 0, b == nblk - 1);
    end
  endtask

  function automatic logic [63:0] beat_of(input int k, input int L);
    logic [63:0] r;
    r = '0;
    for (int j = 0; j < 8; j++) r[63-8*j -: 8] = (8*k + j < L) ? msg[8*k + j] : 8'hFF;
    return r;
  endfunction

  task automatic send_msg(input int L, input bit gaps, input int max_beats, input bit poke_start);
    int nb, k, guard;
    nb = (L + 7) / 8;
    if (max_beats < nb) nb = max_beats;
    k = 0; guard = 0;
    @(negedge clk); msg_bytes = 32'(L); start = 1'b1;
    @(negedge clk); start = 1'b0; msg_bytes = '0;
    while (k < nb && guard < 4000) begin
      in_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      in_data  = beat_of(k, L);
      start    = poke_start && (k == 5);
      msg_bytes = start ? 32'd5 : 32'd0;
      #4;
      if (in_valid && in_ready) k++;
      @(negedge clk);
      guard++;
    end
    in_valid = 1'b0; start = 1'b0; msg_bytes = '0;
    if (k < nb) begin
      total_cnt++;
      $display("FAIL input_timeout: accepted %0d beats, required %0d", k, nb);
    end
  endtask

  task automatic wait_idle();
    int guard;
    guard = 0;
    while ((busy || exp_q.size() != 0) && guard < 500) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 500) begin
      total_cnt++;
      $display("FAIL idle_timeout: busy=%0b pending=%0d required busy=0 pending=0", busy, exp_q.size());
    end
    repeat (2) @(negedge clk);
  endtask

  // Monitor: compares any presented block to the queue head, pops on handshake.
  initial begin
    forever begin
      @(negedge clk);
      #3;
      if (done_due) begin
        check("done_pulse", 512'(done), 512'd1);
        done_due = 1'b0;
      end
      if (rst && blk_valid) begin
        if (exp_q.size() == 0) begin
          total_cnt++;
          $display("FAIL unexpected_blk: got %h expected no block", blk_data);
        end else begin
          check("blk_data", blk_data, exp_q[0].d);
          check("blk_first", 512'(blk_first), 512'(exp_q[0].f));
          check("blk_last", 512'(blk_last), 512'(exp_q[0].l));
          if (blk_ready) begin
            if (exp_q[0].l) done_due = 1'b1;
            void'(exp_q.pop_front());
          end
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [511:0] e;
    int g;
    repeat (3) @(negedge clk);
    #1;
    check("reset_ctrl", 512'({blk_valid, in_ready, blk_first, blk_last, busy, done}), 512'd0);
    check("reset_data", blk_data, 512'd0);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // L=0: single pad-only block, no input consumed
    push_blk({64'h8000_0000_0000_0000, 448'd0}, 1'b1, 1'b1);
    send_msg(0, 1'b0, 100, 1'b0);
    #1;
    check("l0_in_ready", 512'(in_ready), 512'd0);
    wait_idle();

    // L=3 "abc" with junk bytes in the unused lanes
    msg[0] = 8'h61; msg[1] = 8'h62; msg[2] = 8'h63;
    push_blk({64'h6162_6380_0000_0000, 384'd0, 64'h18}, 1'b1, 1'b1);
    send_msg(3, 1'b0, 100, 1'b0);
    wait_idle();

    // L=56: marker spills into word 7, length needs a second block
    for (int i = 0; i < 256; i++) msg[i] = 8'(i / 8 + 1);
    push_blk({{8{8'h01}}, {8{8'h02}}, {8{8'h03}}, {8{8'h04}}, {8{8'h05}}, {8{8'h06}},
              {8{8'h07}}, 64'h8000_0000_0000_0000}, 1'b1, 1'b0);
    push_blk({448'd0, 64'h1C0}, 1'b0, 1'b1);
    send_msg(56, 1'b0, 100, 1'b0);
    wait_idle();

    // L=64 with the consumer stalling 5 cycles on block 0
    push_blk({{8{8'h01}}, {8{8'h02}}, {8{8'h03}}, {8{8'h04}}, {8{8'h05}}, {8{8'h06}},
              {8{8'h07}}, {8{8'h08}}}, 1'b1, 1'b0);
    push_blk({64'h8000_0000_0000_0000, 384'd0, 64'h200}, 1'b0, 1'b1);
    blk_ready = 1'b0;
    send_msg(64, 1'b0, 100, 1'b0);
    g = 0;
    while (!blk_valid && g < 50) begin @(negedge clk); g++; end
    check("l64_blk_valid", 512'(blk_valid), 512'd1);
    repeat (5) @(negedge clk);
    blk_ready = 1'b1;
    wait_idle();

    // L=100 gap-free, then with random in_valid gaps and a stray start mid-run
    for (int i = 0; i < 256; i++) msg[i] = 8'(i * 7 + 3);
    e = '0;
    push_model(100, 8);
    send_msg(100, 1'b0, 100, 1'b0);
    wait_idle();
    push_model(100, 8);
    send_msg(100, 1'b1, 100, 1'b1);
    wait_idle();

    // Reset during block 1 fill aborts the message
    push_model(100, 1);
    send_msg(100, 1'b0, 10, 1'b0);
    rst = 1'b0;
    #1;
    check("abort_ctrl", 512'({blk_valid, in_ready, blk_first, blk_last, busy, done}), 512'd0);
    check("abort_data", blk_data, e);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    msg[0] = 8'h61; msg[1] = 8'h62; msg[2] = 8'h63;
    push_blk({64'h6162_6380_0000_0000, 384'd0, 64'h18}, 1'b1, 1'b1);
    send_msg(3, 1'b0, 100, 1'b0);
    wait_idle();

    check("sb_drained", 512'(exp_q.size()), 512'd0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
